decode_ctrl_stage: RTL and testbench
====================================

DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

Interface
REQ-001 SHALL have parameter ILEN, default 32, meaning instruction width in bits.
REQ-002 SHALL have parameter PC_W, default 32, meaning program-counter width in bits.
REQ-003 SHALL have parameter RA_W, default 5, meaning register-address width in bits.
REQ-004 SHALL have parameter ENABLE_M, default 0, meaning RV32M decode enabled.
REQ-005 SHALL have parameter HAZARD_EN, default 1, meaning load-use stall logic enabled.
REQ-006 SHALL have port clk, in, 1, the single clock; all state on rising edge.
REQ-007 SHALL have port rst, in, 1, synchronous active-low reset.
REQ-008 SHALL have ports in_valid (in, 1), in_ready (out, 1), in_instr (in, ILEN) and in_pc (in, PC_W), forming the IF/ID handshake.
REQ-009 SHALL have port flush, in, 1, which kills the ID/EX contents.
REQ-010 SHALL have ports out_valid (out, 1) and out_ready (in, 1), forming the ID/EX handshake.
REQ-011 SHALL have out_instype (out, 9, one-hot class) and out_subtype (out, 8, one-hot funct3).
REQ-012 SHALL have out_rd, out_rs1 and out_rs2 (out, RA_W each), plus out_f7b5 (out, 1, instr[30]).
REQ-013 SHALL have single-bit outputs out_memread, out_memwrite, out_mem_to_reg, out_regwrite, out_branch, out_alusrc, out_muldiv and out_illegal.
REQ-014 SHALL have out_pc, out, PC_W, the registered in_pc.

Function
REQ-015 SHALL decode instr[6:2] when instr[1:0]==2'b11 and assign instype bits as follows: bit0 OP(01100), 1 OP-IMM(00100), 2 STORE(01000), 3 LOAD(00000), 4 BRANCH(11000), 5 LUI(01101), 6 AUIPC(00101), 7 JAL(11011), 8 JALR(11001).
REQ-016 SHALL, for any other opcode or instr[1:0]!=2'b11, set instype=0, illegal=1, all control bits 0 and subtype=0.
REQ-017 SHALL set subtype=8'b1<<instr[14:12] for OP, OP-IMM, STORE, LOAD, BRANCH and JALR, and 0 for all other classes.
REQ-018 SHALL set memread=mem_to_reg=LOAD and memwrite=STORE.
REQ-019 SHALL set branch=BRANCH|JAL|JALR and alusrc=!(OP|BRANCH).
REQ-020 SHALL set regwrite=(OP|OP-IMM|LOAD|LUI|AUIPC|JAL|JALR)&&(rd!=0).
REQ-021 SHALL set muldiv=1 on OP with funct7==7'b0000001 when ENABLE_M=1; when ENABLE_M=0 that encoding SHALL set illegal=1 and regwrite=0.
REQ-022 SHALL treat rs1 as used by OP, OP-IMM, STORE, LOAD, BRANCH and JALR, and rs2 as used by OP, STORE and BRANCH.
REQ-023 SHALL compute in_ready=rst && !flush && !stall && (!out_valid || out_ready).
REQ-024 SHALL, on in_valid&&in_ready, register decoded fields with 1-cycle latency and set out_valid=1.
REQ-025 SHALL clear out_valid on out_ready without a new accept.
REQ-026 SHALL hold every out_* stable while out_valid&&!out_ready.
REQ-027 SHALL, when HAZARD_EN=1, assert stall if out_valid && out_memread && out_rd!=0 and out_rd matches a used rs of in_instr.
REQ-028 SHALL, while stall is asserted and out_ready=1, load a bubble (out_valid=0, controls 0), so the stall lasts exactly one cycle after the load departs.
REQ-029 SHALL, when HAZARD_EN=0, hold stall at 0.
REQ-030 SHALL give flush priority over accept and hold: next cycle out_valid=0, and the concurrent in_instr is dropped.

Reset
REQ-031 SHALL, on rst==0 at a clock edge, zero all registered outputs, including out_valid, out_pc and out_illegal.
REQ-032 SHALL hold in_ready=0 while rst==0; reset mid-stall SHALL discard the stalled instruction.

Structure
REQ-033 SHALL take opcode constants, instype bit indices and the funct7 M-code from shared package ctrl_pkg.
REQ-034 SHALL place combinational decode in one sub-module, instr_decoder, with the pipeline register and hazard logic in decode_ctrl_stage.

Verification
REQ-035 SHALL cover: add x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle instype=9'h001, subtype=8'h01, rd=3, regwrite=1, alusrc=0.
REQ-036 SHALL cover: lw x5,0(x1) then add x6,x5,x2 -> in_ready=0 one cycle, one bubble, add emitted on the following cycle.
REQ-037 SHALL cover: out_ready=0 for 3 cycles with a valid sw -> outputs unchanged, in_ready=0, memwrite=1 held.
REQ-038 SHALL cover: flush asserted with in_valid=1 -> next cycle out_valid=0; the instruction never appears.
REQ-039 SHALL cover: mul x1,x2,x3 (0x023100B3) with ENABLE_M=0 -> illegal=1, regwrite=0; with ENABLE_M=1 -> muldiv=1, illegal=0.
REQ-040 SHALL cover: rst=0 mid-transfer -> next edge all outputs 0, in_ready=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode constants, instruction-class bit indices and decoded control bundle
package ctrl_pkg;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam int IT_OP     = 0;
  localparam int IT_OPIMM  = 1;
  localparam int IT_STORE  = 2;
  localparam int IT_LOAD   = 3;
  localparam int IT_BRANCH = 4;
  localparam int IT_LUI    = 5;
  localparam int IT_AUIPC  = 6;
  localparam int IT_JAL    = 7;
  localparam int IT_JALR   = 8;
  localparam logic [6:0] F7_M = 7'b0000001;
  typedef struct packed {
    logic [8:0] instype;
    logic [7:0] subtype;
    logic       f7b5;
    logic       memread;
    logic       memwrite;
    logic       mem_to_reg;
    logic       regwrite;
    logic       branch;
    logic       alusrc;
    logic       muldiv;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational RV32I(+M) class and control decode
module instr_decoder
  import ctrl_pkg::*;
#(
  parameter int ILEN     = 32,
  parameter int RA_W     = 5,
  parameter int ENABLE_M = 0
) (
  input  logic [ILEN-1:0] instr,
  output ctrl_t           ctrl,
  output logic [RA_W-1:0] rd,
  output logic [RA_W-1:0] rs1,
  output logic [RA_W-1:0] rs2,
  output logic            rs1_used,
  output logic            rs2_used
);
  logic [4:0] opc;
  logic [8:0] it;
  logic       m_op, no_m, wb;
  assign opc = instr[6:2];
  always_comb begin
    it = '0;
    if (instr[1:0] == 2'b11) begin
      it[IT_OP]     = opc == OPC_OP;
      it[IT_OPIMM]  = opc == OPC_OPIMM;
      it[IT_STORE]  = opc == OPC_STORE;
      it[IT_LOAD]   = opc == OPC_LOAD;
      it[IT_BRANCH] = opc == OPC_BRANCH;
      it[IT_LUI]    = opc == OPC_LUI;
      it[IT_AUIPC]  = opc == OPC_AUIPC;
      it[IT_JAL]    = opc == OPC_JAL;
      it[IT_JALR]   = opc == OPC_JALR;
    end
  end
  assign rd       = RA_W'(instr[11:7]);
  assign rs1      = RA_W'(instr[19:15]);
  assign rs2      = RA_W'(instr[24:20]);
  assign m_op     = it[IT_OP] && instr[31:25] == F7_M;
  assign no_m     = m_op && ENABLE_M == 0;
  // the classes that read rs1 are exactly the ones carrying a funct3 subtype
  assign rs1_used = it[IT_OP] | it[IT_OPIMM] | it[IT_STORE] | it[IT_LOAD] | it[IT_BRANCH] | it[IT_JALR];
  assign rs2_used = it[IT_OP] | it[IT_STORE] | it[IT_BRANCH];
  assign wb       = it[IT_OP] | it[IT_OPIMM] | it[IT_LOAD] | it[IT_LUI] | it[IT_AUIPC] | it[IT_JAL] | it[IT_JALR];
  always_comb begin
    ctrl            = '0;
    ctrl.instype    = it;
    ctrl.subtype    = rs1_used ? 8'd1 << instr[14:12] : 8'd0;
    ctrl.f7b5       = instr[30];
    ctrl.memread    = it[IT_LOAD];
    ctrl.mem_to_reg = it[IT_LOAD];
    ctrl.memwrite   = it[IT_STORE];
    ctrl.branch     = it[IT_BRANCH] | it[IT_JAL] | it[IT_JALR];
    ctrl.alusrc     = |it && !(it[IT_OP] | it[IT_BRANCH]);
    ctrl.regwrite   = wb && instr[11:7] != 5'd0 && !no_m;
    ctrl.muldiv     = m_op && ENABLE_M != 0;
    ctrl.illegal    = ~|it || no_m;
  end
endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: ID stage with ID/EX pipeline register, flush and load-use stall
module decode_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter int ILEN      = 32,
  parameter int PC_W      = 32,
  parameter int RA_W      = 5,
  parameter int ENABLE_M  = 0,
  parameter int HAZARD_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8:0]      out_instype,
  output logic [7:0]      out_subtype,
  output logic [RA_W-1:0] out_rd,
  output logic [RA_W-1:0] out_rs1,
  output logic [RA_W-1:0] out_rs2,
  output logic            out_f7b5,
  output logic            out_memread,
  output logic            out_memwrite,
  output logic            out_mem_to_reg,
  output logic            out_regwrite,
  output logic            out_branch,
  output logic            out_alusrc,
  output logic            out_muldiv,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_pc
);
  ctrl_t           dec, q;
  logic [RA_W-1:0] rd, rs1, rs2;
  logic            rs1_used, rs2_used, stall, accept;
  instr_decoder #(.ILEN(ILEN), .RA_W(RA_W), .ENABLE_M(ENABLE_M)) u_dec (
    .instr(in_instr), .ctrl(dec), .rd(rd), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used)
  );
  assign stall = HAZARD_EN != 0 && out_valid && q.memread && out_rd != '0 &&
                 ((rs1_used && rs1 == out_rd) || (rs2_used && rs2 == out_rd));
  assign in_ready = rst && !flush && !stall && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  // an empty slot is always all-zero, so a drain, a bubble and a flush are the same load
  always_ff @(posedge clk) begin
    if (accept) begin
      out_valid <= 1'b1;
      q         <= dec;
      out_rd    <= rd;
      out_rs1   <= rs1;
      out_rs2   <= rs2;
      out_pc    <= in_pc;
    end else if (!rst || flush || !out_valid || out_ready) begin
      out_valid <= 1'b0;
      q         <= '0;
      out_rd    <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      out_pc    <= '0;
    end
  end
  assign out_instype    = q.instype;
  assign out_subtype    = q.subtype;
  assign out_f7b5       = q.f7b5;
  assign out_memread    = q.memread;
  assign out_memwrite   = q.memwrite;
  assign out_mem_to_reg = q.mem_to_reg;
  assign out_regwrite   = q.regwrite;
  assign out_branch     = q.branch;
  assign out_alusrc     = q.alusrc;
  assign out_muldiv     = q.muldiv;
  assign out_illegal    = q.illegal;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: random + directed check of two stage instances (ENABLE_M=0/1) against a class-table model
module tb_decode_ctrl_stage;
  typedef struct packed {
    logic        v;
    logic [8:0]  it;
    logic [7:0]  st;
    logic [4:0]  rd, rs1, rs2;
    logic        f7b5, mr, mw, m2r, rw, br, as, md, il;
    logic [31:0] pc;
  } exp_t;
  logic        clk = 0, rst = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic        rdy [2];
  exp_t        o [2];
  exp_t        m [2];
  int          n_chk = 0, n_fail = 0;
  logic        ready_seen;
  logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h23, 7'h03, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : u
    logic       v, r, f7b5, mr, mw, m2r, rw, br, as, md, il;
    logic [8:0] it;
    logic [7:0] st;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] pc;
    decode_ctrl_stage #(.ENABLE_M(g)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r), .in_instr(in_instr), .in_pc(in_pc),
      .flush(flush), .out_valid(v), .out_ready(out_ready), .out_instype(it), .out_subtype(st),
      .out_rd(rd), .out_rs1(rs1), .out_rs2(rs2), .out_f7b5(f7b5), .out_memread(mr), .out_memwrite(mw),
      .out_mem_to_reg(m2r), .out_regwrite(rw), .out_branch(br), .out_alusrc(as), .out_muldiv(md),
      .out_illegal(il), .out_pc(pc)
    );
    assign o[g] = {v, it, st, rd, rs1, rs2, f7b5, mr, mw, m2r, rw, br, as, md, il, pc};
    assign rdy[g] = r;
  end
  function automatic int cls(input logic [31:0] i);
    if (i[1:0] != 2'b11) return -1;
    case (i[6:2])
      5'b01100: return 0;
      5'b00100: return 1;
      5'b01000: return 2;
      5'b00000: return 3;
      5'b11000: return 4;
      5'b01101: return 5;
      5'b00101: return 6;
      5'b11011: return 7;
      5'b11001: return 8;
      default:  return -1;
    endcase
  endfunction
  function automatic bit u1(input logic [31:0] i);
    int c;
    c = cls(i);
    return c inside {0, 1, 2, 3, 4, 8};
  endfunction
  function automatic bit u2(input logic [31:0] i);
    int c;
    c = cls(i);
    return c inside {0, 2, 4};
  endfunction
  function automatic exp_t dec(input logic [31:0] i, input logic [31:0] pc, input bit em);
    exp_t e;
    int   c;
    bit   mo;
    e = '0;
    c = cls(i);
    e.v = 1;
    e.pc = pc;
    e.rd = i[11:7];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.f7b5 = i[30];
    if (c < 0) begin
      e.il = 1;
      return e;
    end
    e.it = 9'd1 << c;
    if (u1(i)) e.st = 8'd1 << i[14:12];
    e.mr = c == 3;
    e.m2r = c == 3;
    e.mw = c == 2;
    e.br = c inside {4, 7, 8};
    e.as = !(c == 0 || c == 4);
    mo = c == 0 && i[31:25] == 7'd1;
    e.rw = (c inside {0, 1, 3, 5, 6, 7, 8}) && e.rd != 0 && !(mo && !em);
    e.md = mo && em;
    e.il = mo && !em;
    return e;
  endfunction
  task automatic chk(input string n, input int k, input logic [73:0] a, input logic [73:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%h want=%h", n, k, a, e);
    end
  endtask
  task automatic step(input logic r, input logic iv, input logic fl, input logic ordy,
                      input logic [31:0] ins, input logic [31:0] pc);
    bit st, er;
    rst = r; in_valid = iv; flush = fl; out_ready = ordy; in_instr = ins; in_pc = pc;
    #1;
    st = m[0].v && m[0].mr && m[0].rd != 0 &&
         ((u1(ins) && ins[19:15] == m[0].rd) || (u2(ins) && ins[24:20] == m[0].rd));
    er = r && !fl && !st && (!m[0].v || ordy);
    ready_seen = rdy[0];
    for (int k = 0; k < 2; k++) begin
      chk("in_ready", k, 74'(rdy[k]), 74'(er));
      if (!r || fl) m[k] = '0;
      else if (iv && er) m[k] = dec(ins, pc, k[0]);
      else if (!m[k].v || ordy) m[k] = '0;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("outputs", k, o[k], m[k]);
  endtask
  function automatic logic [31:0] rnd_instr();
    logic [31:0] i;
    int s;
    s = $urandom_range(0, 10);
    i = $urandom;
    if (s > 8) return i;
    i[6:0] = ops[s];
    i[11:7] = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0: i[31:25] = 7'h00;
      1: i[31:25] = 7'h20;
      2: i[31:25] = 7'h01;
      default: ;
    endcase
    return i;
  endfunction
  localparam logic [31:0] ADD3 = 32'h002081B3, LW5 = 32'h0000A283, ADD6 = 32'h00228333;
  localparam logic [31:0] SW = 32'h0020A223, MUL = 32'h023100B3;
  initial begin
    m[0] = '0;
    m[1] = '0;
    chk("pin_add_it", 0, 74'(dec(ADD3, 0, 0).it), 74'h001);
    chk("pin_add_st", 0, 74'(dec(ADD3, 0, 0).st), 74'h01);
    chk("pin_lw_ctl", 0, 74'({dec(LW5, 0, 0).mr, dec(LW5, 0, 0).as, dec(LW5, 0, 0).st}), 74'h304);
    chk("pin_mul_m0", 0, 74'({dec(MUL, 0, 0).il, dec(MUL, 0, 0).rw}), 74'h2);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, ADD3, 32'h100);
    chk("reset_zero", 0, o[0], 74'h0);
    chk("reset_rdy", 0, 74'(ready_seen), 74'h0);
    step(1, 1, 0, 1, ADD3, 32'h100);
    chk("add_it", 0, 74'(o[0].it), 74'h001);
    chk("add_st", 0, 74'(o[0].st), 74'h01);
    chk("add_rd_rw_as", 0, 74'({o[0].rd, o[0].rw, o[0].as}), 74'({5'd3, 1'b1, 1'b0}));
    chk("add_pc", 0, 74'(o[0].pc), 74'h100);
    step(1, 1, 0, 1, LW5, 32'h104);
    step(1, 1, 0, 1, ADD6, 32'h108);
    chk("hz_stall_rdy", 0, 74'(ready_seen), 74'h0);
    chk("hz_bubble", 0, 74'(o[0].v), 74'h0);
    step(1, 1, 0, 1, ADD6, 32'h108);
    chk("hz_rdy_after", 0, 74'(ready_seen), 74'h1);
    chk("hz_add_out", 0, 74'({o[0].v, o[0].rd, o[0].pc}), 74'({1'b1, 5'd6, 32'h108}));
    step(1, 1, 0, 1, SW, 32'h10C);
    for (int c = 0; c < 3; c++) begin
      step(1, 1, 0, 0, ADD3, 32'h110);
      chk("hold_rdy", c, 74'(ready_seen), 74'h0);
      chk("hold_sw", c, 74'({o[0].v, o[0].mw, o[0].pc}), 74'({1'b1, 1'b1, 32'h10C}));
    end
    step(1, 0, 0, 1, 0, 0);
    chk("drain", 0, 74'(o[0].v), 74'h0);
    step(1, 1, 1, 1, ADD3, 32'h200);
    chk("flush_drop", 0, o[0], 74'h0);
    step(1, 1, 0, 1, MUL, 32'h204);
    chk("mul_m0", 0, 74'({o[0].il, o[0].rw, o[0].md}), 74'b100);
    chk("mul_m1", 1, 74'({o[1].il, o[1].rw, o[1].md}), 74'b011);
    step(1, 1, 0, 0, ADD3, 32'h208);
    step(0, 1, 0, 0, ADD3, 32'h20C);
    chk("rst_mid_rdy", 0, 74'(ready_seen), 74'h0);
    chk("rst_mid_a", 0, o[0], 74'h0);
    chk("rst_mid_b", 1, o[1], 74'h0);
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0, rnd_instr(), $urandom);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
